// File: rtl/rpn_pkg.sv
// Shared opcodes, FSM states and error codes for the RPN stack controller.
package rpn_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_EQ  = 3'd5
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PUSH_N = 3'd1,
        ST_POP_B  = 3'd2,
        ST_POP_A  = 3'd3,
        ST_CAP_A  = 3'd4,
        ST_PUSH_R = 3'd5,
        ST_EMIT   = 3'd6,
        ST_ERR    = 3'd7
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_UNDER   = 2'b01;
    localparam logic [1:0] ERR_OVER    = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL = 2'b11;

endpackage

// File: rtl/rpn_alu.sv
// Combinational binary-operator unit: result = f(A, B) for ADD..XOR.
// Define RPN_SAT_EN to make ADD saturate high and SUB saturate at zero.
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [2:0]   i_op,
    output logic [W-1:0] o_res
);

`ifdef RPN_SAT_EN
    logic [W:0] w_sum;
    assign w_sum = {1'b0, i_a} + {1'b0, i_b};
`endif

    // Operator decode; EQ and illegal codes never reach the push path.
    always_comb begin
        o_res = {W{1'b0}};
        case (i_op)
`ifdef RPN_SAT_EN
            OP_ADD:  o_res = w_sum[W] ? {W{1'b1}} : w_sum[W-1:0];
            OP_SUB:  o_res = (i_a < i_b) ? {W{1'b0}} : (i_a - i_b);
`else
            OP_ADD:  o_res = i_a + i_b;
            OP_SUB:  o_res = i_a - i_b;
`endif
            OP_AND:  o_res = i_a & i_b;
            OP_OR:   o_res = i_a | i_b;
            OP_XOR:  o_res = i_a ^ i_b;
            default: o_res = {W{1'b0}};
        endcase
    end

endmodule

// File: rtl/rpn_stack_ctrl.sv
// RPN evaluator driving an external W-bit LIFO; tracks occupancy and flags errors.
// Optional build macro RPN_SAT_EN selects saturating ADD/SUB inside rpn_alu.
module rpn_stack_ctrl
    import rpn_pkg::*;
#(
    parameter  int W     = 4,
    parameter  int DEPTH = 8,
    localparam int DW    = $clog2(DEPTH + 1)
) (
    input  logic          Clk,
    input  logic          RstN,
    input  logic          Tok_Valid,
    output logic          Tok_Ready,
    input  logic          Tok_Is_Op,
    input  logic [W-1:0]  Tok_Data,
    output logic          Stk_Push,
    output logic          Stk_Pop,
    output logic [W-1:0]  Stk_Data_In,
    input  logic [W-1:0]  Stk_Data_Out,
    output logic [W-1:0]  Result,
    output logic          Result_Valid,
    output logic [DW-1:0] Depth,
    output logic          Error,
    output logic [1:0]    Err_Code
);

    state_e        r_state;
    logic          r_ready;
    logic          r_push;
    logic          r_pop;
    logic [W-1:0]  r_din;
    logic [W-1:0]  r_res;
    logic          r_res_v;
    logic [DW-1:0] r_depth;
    logic          r_err;
    logic [1:0]    r_code;
    logic [W-1:0]  r_b;
    logic [2:0]    r_op;
    logic [W-1:0]  w_alu;
    logic [2:0]    w_tok_op;
    logic          w_unused_tok;

    assign w_tok_op     = Tok_Data[2:0];
    assign w_unused_tok = ^Tok_Data[W-1:3];

    // A arrives on Stk_Data_Out during CAP_A; B was latched in POP_A.
    rpn_alu #(.W(W)) u_alu (
        .i_a   (Stk_Data_Out),
        .i_b   (r_b),
        .i_op  (r_op),
        .o_res (w_alu)
    );

    // Controller FSM; every output is a register updated here.
    always_ff @(posedge Clk) begin
        if (!RstN) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
            r_push  <= 1'b0;
            r_pop   <= 1'b0;
            r_din   <= {W{1'b0}};
            r_res   <= {W{1'b0}};
            r_res_v <= 1'b0;
            r_depth <= {DW{1'b0}};
            r_err   <= 1'b0;
            r_code  <= ERR_NONE;
            r_b     <= {W{1'b0}};
            r_op    <= 3'd0;
        end else begin
            r_push  <= 1'b0;
            r_pop   <= 1'b0;
            r_res_v <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (Tok_Valid && r_ready) begin
                        r_ready <= 1'b0;
                        r_op    <= w_tok_op;
                        if (!Tok_Is_Op) begin
                            if (r_depth == DW'(DEPTH)) begin
                                r_state <= ST_ERR;
                                r_err   <= 1'b1;
                                r_code  <= ERR_OVER;
                            end else begin
                                r_state <= ST_PUSH_N;
                                r_push  <= 1'b1;
                                r_din   <= Tok_Data;
                                r_depth <= r_depth + DW'(1);
                            end
                        end else if (w_tok_op > 3'(OP_EQ)) begin
                            r_state <= ST_ERR;
                            r_err   <= 1'b1;
                            r_code  <= ERR_ILLEGAL;
                        end else if ((w_tok_op == 3'(OP_EQ)) ? (r_depth == DW'(0))
                                                            : (r_depth < DW'(2))) begin
                            r_state <= ST_ERR;
                            r_err   <= 1'b1;
                            r_code  <= ERR_UNDER;
                        end else begin
                            r_state <= ST_POP_B;
                            r_pop   <= 1'b1;
                            r_depth <= r_depth - DW'(1);
                        end
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                ST_PUSH_N, ST_PUSH_R: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
                ST_POP_B: begin
                    if (r_op == 3'(OP_EQ)) begin
                        r_state <= ST_EMIT;
                    end else begin
                        r_state <= ST_POP_A;
                        r_pop   <= 1'b1;
                        r_depth <= r_depth - DW'(1);
                    end
                end
                ST_POP_A: begin
                    r_b     <= Stk_Data_Out;
                    r_state <= ST_CAP_A;
                end
                ST_CAP_A: begin
                    r_din   <= w_alu;
                    r_push  <= 1'b1;
                    r_depth <= r_depth + DW'(1);
                    r_state <= ST_PUSH_R;
                end
                ST_EMIT: begin
                    r_res   <= Stk_Data_Out;
                    r_res_v <= 1'b1;
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
                ST_ERR: begin
                    r_state <= ST_ERR;
                    r_ready <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign Tok_Ready    = r_ready;
    assign Stk_Push     = r_push;
    assign Stk_Pop      = r_pop;
    assign Stk_Data_In  = r_din;
    assign Result       = r_res;
    assign Result_Valid = r_res_v;
    assign Depth        = r_depth;
    assign Error        = r_err;
    assign Err_Code     = r_code;

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Self-checking bench: behavioural 4x8 LIFO, token model and result scoreboard.
module tb_rpn_stack_ctrl;

    logic       Clk = 1'b0;
    logic       RstN = 1'b0;
    logic       Tok_Valid = 1'b0;
    logic       Tok_Ready;
    logic       Tok_Is_Op = 1'b0;
    logic [3:0] Tok_Data = 4'd0;
    logic       Stk_Push, Stk_Pop;
    logic [3:0] Stk_Data_In;
    logic [3:0] Stk_Data_Out;
    logic [3:0] Result;
    logic       Result_Valid;
    logic [3:0] Depth;
    logic       Error;
    logic [1:0] Err_Code;

    int n_tests = 0;
    int n_fail  = 0;
    int n_push  = 0;
    int n_pop   = 0;
    int n_both  = 0;
    int n_rv    = 0;

    logic [3:0] exp_q[$];
    logic [3:0] m_stk[$];

    always #5 Clk = ~Clk;

    rpn_stack_ctrl #(.W(4), .DEPTH(8)) dut (
        .Clk(Clk), .RstN(RstN),
        .Tok_Valid(Tok_Valid), .Tok_Ready(Tok_Ready),
        .Tok_Is_Op(Tok_Is_Op), .Tok_Data(Tok_Data),
        .Stk_Push(Stk_Push), .Stk_Pop(Stk_Pop),
        .Stk_Data_In(Stk_Data_In), .Stk_Data_Out(Stk_Data_Out),
        .Result(Result), .Result_Valid(Result_Valid),
        .Depth(Depth), .Error(Error), .Err_Code(Err_Code)
    );

    // Behavioural LIFO; popped data appears the cycle after the pop strobe.
    logic [3:0] s_mem [8];
    logic [3:0] s_sp;
    always_ff @(posedge Clk) begin
        if (!RstN) begin
            s_sp         <= 4'd0;
            Stk_Data_Out <= 4'd0;
        end else if (Stk_Push && s_sp < 4'd8) begin
            s_mem[s_sp[2:0]] <= Stk_Data_In;
            s_sp             <= s_sp + 4'd1;
        end else if (Stk_Pop && s_sp > 4'd0) begin
            Stk_Data_Out <= s_mem[s_sp[2:0] - 3'd1];
            s_sp         <= s_sp - 4'd1;
        end
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Strobe counters and scoreboard compare, sampled mid-cycle.
    always @(negedge Clk) begin
        if (Stk_Push) n_push++;
        if (Stk_Pop) n_pop++;
        if (Stk_Push && Stk_Pop) n_both++;
        if (Result_Valid) begin
            n_rv++;
            if (exp_q.size() == 0) chk("result_unexpected", int'(Result), -1);
            else chk("result", int'(Result), int'(exp_q.pop_front()));
        end
    end

    function automatic logic [3:0] m_alu(input logic [2:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
        logic [4:0] s;
        logic [3:0] r;
        case (op)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[3:0];
`ifdef RPN_SAT_EN
                if (s[4]) r = 4'hF;
`endif
            end
            3'd1: begin
                r = a - b;
`ifdef RPN_SAT_EN
                if (a < b) r = 4'h0;
`endif
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            default: r = a ^ b;
        endcase
        return r;
    endfunction

    // Reference model update for an accepted token.
    task automatic model_tok(input logic is_op, input logic [3:0] d);
        logic [3:0] a, b;
        if (!is_op) begin
            if (m_stk.size() < 8) m_stk.push_back(d);
        end else if (d[2:0] == 3'd5) begin
            if (m_stk.size() > 0) exp_q.push_back(m_stk.pop_back());
        end else if (d[2:0] < 3'd5 && m_stk.size() >= 2) begin
            b = m_stk.pop_back();
            a = m_stk.pop_back();
            m_stk.push_back(m_alu(d[2:0], a, b));
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        RstN = 1'b0;
        Tok_Valid = 1'b0;
        @(negedge Clk);
        chk("rst_push", Stk_Push, 0);
        chk("rst_pop", Stk_Pop, 0);
        chk("rst_depth", Depth, 0);
        chk("rst_error", Error, 0);
        chk("rst_code", Err_Code, 0);
        chk("rst_result", Result, 0);
        chk("rst_rvalid", Result_Valid, 0);
        chk("rst_ready", Tok_Ready, 0);
        m_stk.delete();
        exp_q.delete();
        RstN = 1'b1;
        @(negedge Clk);
        chk("rst_ready_after", Tok_Ready, 1);
    endtask

    task automatic send_tok(input logic is_op, input logic [3:0] d);
        int n = 0;
        @(negedge Clk);
        Tok_Valid = 1'b1;
        Tok_Is_Op = is_op;
        Tok_Data  = d;
        while (!Tok_Ready && n < 20) begin
            @(negedge Clk);
            n++;
        end
        chk("accept", Tok_Ready, 1);
        if (Tok_Ready) begin
            @(posedge Clk);
            model_tok(is_op, d);
            @(negedge Clk);
        end
        Tok_Valid = 1'b0;
    endtask

    task automatic expect_reject(input logic is_op, input logic [3:0] d);
        int acc = 0;
        @(negedge Clk);
        Tok_Valid = 1'b1;
        Tok_Is_Op = is_op;
        Tok_Data  = d;
        repeat (10) begin
            @(negedge Clk);
            if (Tok_Ready) acc++;
        end
        Tok_Valid = 1'b0;
        chk("reject", acc, 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!Tok_Ready && n < 20) begin
            @(negedge Clk);
            n++;
        end
        chk("idle_timeout", Tok_Ready, 1);
        repeat (2) @(negedge Clk);
    endtask

    initial begin
        int p0, rv0, c;
        logic [3:0] v;

        do_reset();

        // T1: 3 4 ADD EQ
        rv0 = n_rv;
        send_tok(1'b0, 4'd3); send_tok(1'b0, 4'd4);
        send_tok(1'b1, 4'd0); send_tok(1'b1, 4'd5);
        wait_idle();
        chk("t1_result", Result, 7);
        chk("t1_pulses", n_rv - rv0, 1);
        chk("t1_depth", Depth, 0);
        chk("t1_sb_empty", exp_q.size(), 0);

        // T2: 2 5 SUB EQ
        send_tok(1'b0, 4'd2); send_tok(1'b0, 4'd5);
        send_tok(1'b1, 4'd1); send_tok(1'b1, 4'd5);
        wait_idle();
`ifdef RPN_SAT_EN
        chk("t2_result", Result, 0);
`else
        chk("t2_result", Result, 13);
`endif

        // Logic ops on 12,10
        for (int k = 2; k <= 4; k++) begin
            send_tok(1'b0, 4'd12); send_tok(1'b0, 4'd10);
            send_tok(1'b1, 4'(k)); send_tok(1'b1, 4'd5);
        end
        wait_idle();
        chk("logic_last", Result, 6);

        // Random legal token stream against the model
        for (int i = 0; i < 60; i++) begin
            c = (m_stk.size() < 2) ? 0 : (m_stk.size() == 8) ? 1 : int'($urandom_range(0, 1));
            v = 4'($urandom_range(0, 15));
            if (c == 0) send_tok(1'b0, v);
            else send_tok(1'b1, 4'($urandom_range(0, 4)));
            wait_idle();
            chk("rand_depth", Depth, m_stk.size());
        end
        while (m_stk.size() > 0) begin
            send_tok(1'b1, 4'd5);
            wait_idle();
        end
        chk("rand_sb_empty", exp_q.size(), 0);
        chk("rand_err", Error, 0);

        // T3: overflow
        do_reset();
        p0 = n_push;
        for (int i = 0; i < 8; i++) send_tok(1'b0, 4'(i + 1));
        wait_idle();
        chk("t3_depth_full", Depth, 8);
        send_tok(1'b0, 4'd9);
        repeat (4) @(negedge Clk);
        chk("t3_error", Error, 1);
        chk("t3_code", Err_Code, 2);
        chk("t3_depth", Depth, 8);
        chk("t3_pushes", n_push - p0, 8);
        chk("t3_ready", Tok_Ready, 0);

        // T4: underflow
        do_reset();
        p0 = n_pop;
        send_tok(1'b0, 4'd6);
        send_tok(1'b1, 4'd0);
        repeat (4) @(negedge Clk);
        chk("t4_error", Error, 1);
        chk("t4_code", Err_Code, 1);
        chk("t4_pops", n_pop - p0, 0);
        chk("t4_ready", Tok_Ready, 0);
        chk("t4_depth", Depth, 1);

        // T5: illegal opcode, then a rejected token
        do_reset();
        send_tok(1'b0, 4'd1); send_tok(1'b0, 4'd2);
        wait_idle();
        send_tok(1'b1, 4'd7);
        repeat (2) @(negedge Clk);
        chk("t5_code", Err_Code, 3);
        expect_reject(1'b0, 4'd4);
        chk("t5_code_held", Err_Code, 3);
        chk("t5_depth", Depth, 2);

        // T6: reset during POP_A of ADD
        do_reset();
        send_tok(1'b0, 4'd1); send_tok(1'b0, 4'd2);
        wait_idle();
        send_tok(1'b1, 4'd0);
        @(negedge Clk);
        chk("t6_popa_strobe", Stk_Pop, 1);
        RstN = 1'b0;
        @(negedge Clk);
        chk("t6_depth", Depth, 0);
        chk("t6_push", Stk_Push, 0);
        chk("t6_pop", Stk_Pop, 0);
        chk("t6_error", Error, 0);
        m_stk.delete();
        exp_q.delete();
        RstN = 1'b1;
        p0 = n_push + n_pop;
        repeat (4) @(negedge Clk);
        chk("t6_ready", Tok_Ready, 1);
        chk("t6_no_strobes", n_push + n_pop - p0, 0);
        send_tok(1'b0, 4'd9); send_tok(1'b1, 4'd5);
        wait_idle();
        chk("t6_result", Result, 9);
        chk("t6_sb_empty", exp_q.size(), 0);

        chk("strobe_exclusive", n_both, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
